// File: rtl/ofs_fim_pcie_ss_rxcrdt_sched_if.sv
// Release-event inputs and rxcrdt update outputs of the RX credit return scheduler.
// master: drives releases and observes updates; slave: the scheduler itself.
interface ofs_fim_pcie_ss_rxcrdt_sched_if;
  logic        cpl_rel_valid;
  logic [11:0] cpl_rel_data_cr;
  logic        req_rel_valid;
  logic        req_rel_np;
  logic [11:0] req_rel_data_cr;
  logic        rxcrdt_tvalid;
  logic [18:0] rxcrdt_tdata;
  logic        init_done;

  modport master (
    output cpl_rel_valid, cpl_rel_data_cr, req_rel_valid, req_rel_np, req_rel_data_cr,
    input  rxcrdt_tvalid, rxcrdt_tdata, init_done
  );

  modport slave (
    input  cpl_rel_valid, cpl_rel_data_cr, req_rel_valid, req_rel_np, req_rel_data_cr,
    output rxcrdt_tvalid, rxcrdt_tdata, init_done
  );
endinterface

// File: rtl/ofs_fim_pcie_ss_rxcrdt_sched.sv
// RX credit return scheduler: advertises initial credits, then coalesces buffer releases
// into six accumulators and returns them round-robin. OFS_FIM_PCIE_SS_RXCRDT_SCHED_IMMEDIATE_EN
// makes every non-zero accumulator eligible each cycle (no threshold/timeout coalescing).
//
// state   | meaning
// ST_INIT | emit initial credits for types 0..5, one per cycle
// ST_RUN  | round-robin return of accumulated credits
module ofs_fim_pcie_ss_rxcrdt_sched #(
  parameter int INIT_PH   = 64,
  parameter int INIT_NPH  = 64,
  parameter int INIT_CPLH = 128,
  parameter int INIT_PD   = 1024,
  parameter int INIT_NPD  = 64,
  parameter int INIT_CPLD = 2048,
  parameter int THRESH_H  = 4,
  parameter int THRESH_D  = 32,
  parameter int TIMEOUT   = 64
) (
  input logic                           clk,
  input logic                           rst_n,
  ofs_fim_pcie_ss_rxcrdt_sched_if.slave rx
);

  localparam int             TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMAX  = TW'(TIMEOUT);
  localparam logic [17:0]    THR_H = 18'(THRESH_H);
  localparam logic [17:0]    THR_D = 18'(THRESH_D);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [2:0]    init_idx_q, init_idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    rr_q, rr_d;
  logic [5:0]    flush_q, flush_d;
  logic          sat_q, sat_d;
  logic [17:0]   acc_q [6];
  logic [17:0]   acc_d [6];
  logic [11:0]   add_v [6];
  logic [15:0]   cnt [6];
  logic [5:0]    elig, nz;
  logic          expired, found, issue;
  logic [2:0]    sel, rr_idx;
  logic [15:0]   sel_cnt, sub;
  logic [18:0]   sum;
  logic          tvalid_q, tvalid_d;
  logic [18:0]   tdata_q, tdata_d;
  logic          init_done_q;
  logic          req_p, req_np;

  function automatic logic [15:0] init_val(input logic [2:0] t);
    case (t)
      3'd0:    return 16'(INIT_PH);
      3'd1:    return 16'(INIT_NPH);
      3'd2:    return 16'(INIT_CPLH);
      3'd3:    return 16'(INIT_PD);
      3'd4:    return 16'(INIT_NPD);
      default: return 16'(INIT_CPLD);
    endcase
  endfunction

  assign req_p    = rx.req_rel_valid & ~rx.req_rel_np;
  assign req_np   = rx.req_rel_valid & rx.req_rel_np;
  assign add_v[0] = {11'd0, req_p};
  assign add_v[1] = {11'd0, req_np};
  assign add_v[2] = {11'd0, rx.cpl_rel_valid};
  assign add_v[3] = req_p ? rx.req_rel_data_cr : 12'd0;
  assign add_v[4] = req_np ? rx.req_rel_data_cr : 12'd0;
  assign add_v[5] = rx.cpl_rel_valid ? rx.cpl_rel_data_cr : 12'd0;
  assign expired  = (timer_q == TMAX);

  always_comb begin : p_elig
    elig = '0;
    nz   = '0;
    for (int t = 0; t < 6; t++) begin
      cnt[t] = (acc_q[t] > 18'h0FFFF) ? 16'hFFFF : acc_q[t][15:0];
      nz[t]  = (acc_q[t] != '0);
`ifdef OFS_FIM_PCIE_SS_RXCRDT_SCHED_IMMEDIATE_EN
      elig[t] = nz[t];
`else
      elig[t] = (acc_q[t] >= ((t < 3) ? THR_H : THR_D)) || (nz[t] && (expired || flush_q[t]));
`endif
    end
  end

  // Walk backwards so the candidate nearest to rr_q+1 is the one left in sel.
  always_comb begin : p_arb
    found   = 1'b0;
    sel     = '0;
    sel_cnt = '0;
    rr_idx  = '0;
    for (int k = 5; k >= 0; k--) begin
      rr_idx = 3'((int'(rr_q) + 1 + k) % 6);
      if (elig[rr_idx]) begin
        found   = 1'b1;
        sel     = rr_idx;
        sel_cnt = cnt[rr_idx];
      end
    end
  end

  always_comb begin : p_fsm
    state_d    = state_q;
    init_idx_d = init_idx_q;
    timer_d    = timer_q;
    rr_d       = rr_q;
    tvalid_d   = 1'b0;
    tdata_d    = '0;
    issue      = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        tvalid_d = 1'b1;
        tdata_d  = {init_idx_q, init_val(init_idx_q)};
        timer_d  = '0;
        if (init_idx_q == 3'd5) begin
          state_d    = ST_RUN;
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + 3'd1;
        end
      end
      ST_RUN: begin
        if (found) begin
          issue    = 1'b1;
          tvalid_d = 1'b1;
          tdata_d  = {sel, sel_cnt};
          rr_d     = sel;
          timer_d  = '0;
        end else if (timer_q != TMAX) begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  // Types still non-zero at expiry stay flushable after the timer restarts on the first flush.
  always_comb begin : p_flush
    flush_d = flush_q;
`ifndef OFS_FIM_PCIE_SS_RXCRDT_SCHED_IMMEDIATE_EN
    if (state_q == ST_RUN) begin
      if (expired) flush_d = flush_q | nz;
      if (issue)   flush_d[sel] = 1'b0;
    end
`endif
  end

  always_comb begin : p_acc
    sat_d = sat_q;
    sum   = '0;
    sub   = '0;
    for (int t = 0; t < 6; t++) begin
      sub = (issue && (sel == 3'(t))) ? sel_cnt : 16'd0;
      sum = {1'b0, acc_q[t]} - {3'd0, sub} + {7'd0, add_v[t]};
      if (sum[18]) begin
        acc_d[t] = '1;
        sat_d    = 1'b1;
      end else begin
        acc_d[t] = sum[17:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_idx_q  <= '0;
      timer_q     <= '0;
      rr_q        <= '0;
      flush_q     <= '0;
      sat_q       <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      init_done_q <= 1'b0;
      for (int t = 0; t < 6; t++) acc_q[t] <= '0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      timer_q     <= timer_d;
      rr_q        <= rr_d;
      flush_q     <= flush_d;
      sat_q       <= sat_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      init_done_q <= (state_q == ST_RUN);
      for (int t = 0; t < 6; t++) acc_q[t] <= acc_d[t];
    end
  end

  assign rx.rxcrdt_tvalid = tvalid_q;
  assign rx.rxcrdt_tdata  = tdata_q;
  assign rx.init_done     = init_done_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) assert (!sat_q) else $error("rxcrdt credit accumulator saturated");
  end
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rxcrdt_sched.sv
// Directed bench for ofs_fim_pcie_ss_rxcrdt_sched: vector table for INIT and coalescing,
// hand sequences for timeout flush, sustained traffic, reset during INIT.
module tb_ofs_fim_pcie_ss_rxcrdt_sched;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ofs_fim_pcie_ss_rxcrdt_sched_if bus ();
  ofs_fim_pcie_ss_rxcrdt_sched dut (.clk(clk), .rst_n(rst_n), .rx(bus));

  typedef struct {
    bit        rst;
    bit        cv;
    bit [11:0] cd;
    bit        rv;
    bit        rnp;
    bit [11:0] rd;
    bit        ev;
    bit [2:0]  et;
    bit [15:0] ec;
    bit        ed;
  } vec_t;

`ifdef OFS_FIM_PCIE_SS_RXCRDT_SCHED_IMMEDIATE_EN
  localparam int N_ROWS = 9;
`else
  localparam int N_ROWS = 16;
`endif

  vec_t vecs [16];
  int   n_checks = 0;
  int   n_errors = 0;
  int   init_vals [6] = '{64, 64, 128, 1024, 64, 2048};
  int   emit_sum [6] = '{default: 0};
  int   last_slot [6] = '{default: -1};
  int   max_gap [6] = '{default: 0};
  int   slot_idx = 0;
  int   mt;
  bit   stress_on = 1'b0;
  bit   stress_q = 1'b0;
  bit   bad_type = 1'b0;

  // Monitor: per-type emitted totals and the worst count of other updates between two
  // services of the same type while sustained traffic is running.
  always @(negedge clk) begin
    if (stress_on && !stress_q) begin
      for (int t = 0; t < 6; t++) begin
        last_slot[t] = -1;
        max_gap[t]   = 0;
      end
    end
    stress_q = stress_on;
    if (rst_n && bus.rxcrdt_tvalid) begin
      mt = int'(bus.rxcrdt_tdata[18:16]);
      if (mt > 5) begin
        bad_type = 1'b1;
      end else begin
        emit_sum[mt] += int'(bus.rxcrdt_tdata[15:0]);
        if (stress_on) begin
          if (last_slot[mt] >= 0 && (slot_idx - last_slot[mt] - 1) > max_gap[mt])
            max_gap[mt] = slot_idx - last_slot[mt] - 1;
          last_slot[mt] = slot_idx;
        end
      end
      slot_idx++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(bit r, bit cv, int cd, bit rv, bit rnp, int rd,
                              bit ev, int et, int ec, bit ed);
    vec_t v;
    v.rst = r;  v.cv = cv;  v.cd = 12'(cd); v.rv = rv; v.rnp = rnp; v.rd = 12'(rd);
    v.ev  = ev; v.et = 3'(et); v.ec = 16'(ec); v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.cpl_rel_valid   = 1'b0;
    bus.cpl_rel_data_cr = '0;
    bus.req_rel_valid   = 1'b0;
    bus.req_rel_np      = 1'b0;
    bus.req_rel_data_cr = '0;
  endtask

  task automatic chk_upd(input string nm, input int t, input int c);
    chk(nm, {12'd0, bus.rxcrdt_tvalid, bus.rxcrdt_tdata}, {12'd0, 1'b1, 3'(t), 16'(c)});
  endtask

  initial begin
    int base [6];
    int exp_sum [6];
    int k;
    logic [18:0] dm, em;
    vec_t v;

    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 64, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 64, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0, 1, 2, 128, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0, 1, 3, 1024, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 0, 1, 4, 64, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 0, 1, 5, 2048, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[9]  = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 1);
    vecs[10] = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 1);
    vecs[11] = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 1);
    vecs[12] = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 1);
    vecs[13] = mk(1, 0, 0, 0, 0, 0, 1, 2, 4, 1);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 1, 5, 32, 1);
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    rst_n = 1'b0;
    idle();
    @(negedge clk);

    for (int i = 0; i < N_ROWS; i++) begin
      v = vecs[i];
      rst_n               = v.rst;
      bus.cpl_rel_valid   = v.cv;
      bus.cpl_rel_data_cr = v.cd;
      bus.req_rel_valid   = v.rv;
      bus.req_rel_np      = v.rnp;
      bus.req_rel_data_cr = v.rd;
      @(negedge clk);
      dm = bus.rxcrdt_tdata;
      em = {v.et, v.ec};
      if (!(v.ev || !v.rst)) begin
        dm = '0;
        em = '0;
      end
      chk($sformatf("row%0d", i), {11'd0, bus.rxcrdt_tvalid, dm, bus.init_done},
          {11'd0, v.ev, em, v.ed});
    end
    idle();

`ifdef OFS_FIM_PCIE_SS_RXCRDT_SCHED_IMMEDIATE_EN
    bus.cpl_rel_valid   = 1'b1;
    bus.cpl_rel_data_cr = 12'd1;
    @(negedge clk);
    idle();
    chk("imm_acc_cycle_tvalid", {31'd0, bus.rxcrdt_tvalid}, 32'd0);
    @(negedge clk);
    chk_upd("imm_cplh", 2, 1);
    @(negedge clk);
    chk_upd("imm_cpld", 5, 1);
    @(negedge clk);
    chk("imm_quiet_after", {31'd0, bus.rxcrdt_tvalid}, 32'd0);
`else
    // Last update was two negedges ago, so the timer reaches TIMEOUT 63 cycles after this release.
    bus.req_rel_valid   = 1'b1;
    bus.req_rel_np      = 1'b0;
    bus.req_rel_data_cr = 12'd2;
    @(negedge clk);
    idle();
    k = 0;
    while (!bus.rxcrdt_tvalid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", 32'(k), 32'd63);
    chk_upd("timeout_ph", 0, 1);
    @(negedge clk);
    chk_upd("timeout_pd", 3, 2);
    @(negedge clk);
    chk("timeout_quiet_after", {31'd0, bus.rxcrdt_tvalid}, 32'd0);
`endif

    for (int t = 0; t < 6; t++) begin
      base[t]    = emit_sum[t];
      exp_sum[t] = 0;
    end
    stress_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.cpl_rel_valid   = 1'b1;
      bus.cpl_rel_data_cr = 12'($urandom_range(40, 8));
      bus.req_rel_valid   = 1'b1;
      bus.req_rel_np      = 1'b1;
      bus.req_rel_data_cr = 12'($urandom_range(60, 16));
      exp_sum[1] += 1;
      exp_sum[2] += 1;
      exp_sum[4] += int'(bus.req_rel_data_cr);
      exp_sum[5] += int'(bus.cpl_rel_data_cr);
      @(negedge clk);
    end
    idle();
    stress_on = 1'b0;
    repeat (200) @(negedge clk);
    for (int t = 0; t < 6; t++)
      chk($sformatf("stress_sum_type%0d", t), 32'(emit_sum[t] - base[t]), 32'(exp_sum[t]));
    // Each active type re-qualifies within 4 cycles of service and has at most 3 rivals.
    for (int t = 1; t < 6; t++) begin
      if (t == 3) continue;
      n_checks++;
      if (max_gap[t] > 6) begin
        n_errors++;
        $display("FAIL stress_gap_type%0d: got %0d other updates, required at most 6", t, max_gap[t]);
      end
    end

    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_from_run", {11'd0, bus.rxcrdt_tvalid, bus.rxcrdt_tdata, bus.init_done}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_upd($sformatf("init_a%0d", i), i, init_vals[i]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_init", {11'd0, bus.rxcrdt_tvalid, bus.rxcrdt_tdata, bus.init_done}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_upd($sformatf("init_b%0d", i), i, init_vals[i]);
      chk($sformatf("init_b%0d_done", i), {31'd0, bus.init_done}, 32'd0);
    end
    @(negedge clk);
    chk("init_b_done", {30'd0, bus.rxcrdt_tvalid, bus.init_done}, 32'd1);

    chk("type_code_range", {31'd0, bad_type}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
